// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexed common-anode seven-segment scanner with
// double-buffered per-digit value/dp/blank registers and a dead-time between digits.

// segment_decoder: hex digit to active-low segments, bit 0 = a ... bit 6 = g
module segment_decoder (
   input  logic [3:0] hex_i,
   output logic [6:0] seg_n_o
);
   always_comb begin
      case (hex_i)
         4'h0:    seg_n_o = 7'h40;
         4'h1:    seg_n_o = 7'h79;
         4'h2:    seg_n_o = 7'h24;
         4'h3:    seg_n_o = 7'h30;
         4'h4:    seg_n_o = 7'h19;
         4'h5:    seg_n_o = 7'h12;
         4'h6:    seg_n_o = 7'h02;
         4'h7:    seg_n_o = 7'h78;
         4'h8:    seg_n_o = 7'h00;
         4'h9:    seg_n_o = 7'h10;
         4'hA:    seg_n_o = 7'h08;
         4'hB:    seg_n_o = 7'h03;
         4'hC:    seg_n_o = 7'h46;
         4'hD:    seg_n_o = 7'h21;
         4'hE:    seg_n_o = 7'h06;
         default: seg_n_o = 7'h0E;
      endcase
   end
endmodule

module seg_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 16,
   parameter int IW           = $clog2(NUM_DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  wr_en,
   output logic                  wr_ready,
   input  logic [IW-1:0]         wr_idx,
   input  logic [3:0]            wr_data,
   input  logic                  wr_dp,
   input  logic                  wr_blank,
   output logic [6:0]            seg_n,
   output logic                  dp_n,
   output logic [NUM_DIGITS-1:0] an_n,
   output logic [IW-1:0]         digit_idx,
   output logic                  frame_done
);
   localparam int CW = $clog2(CLK_DIV > BLANK_CYCLES ? CLK_DIV : BLANK_CYCLES);

   if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || CLK_DIV < 2 || BLANK_CYCLES < 1) begin : g_bad_params
      $error("seg_scan_controller: illegal parameter set");
   end

   typedef enum logic [1:0] {OFF, BLANK, DRIVE} state_t;

   state_t                         state_q, state_d;
   logic [CW-1:0]                  cnt_q, cnt_d;
   logic [IW-1:0]                  idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0]     sh_val_q, sh_val_d, act_val_q, act_val_d;
   logic [NUM_DIGITS-1:0]          sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0]          sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
   logic [NUM_DIGITS-1:0]          an_n_q, an_n_d;
   logic [6:0]                     seg_n_q, seg_n_d, dec_seg;
   logic [3:0]                     dec_hex;
   logic                           dp_n_q, dp_n_d, frame_done_q, frame_done_d;
   logic                           wr_ready_q, wr_ready_d;
   logic                           last_drive, frame_end, wr_fire, commit, drive_d, lit;

   always_comb begin
      last_drive = (state_q == DRIVE) && (cnt_q == CW'(CLK_DIV - 1));
      frame_end  = last_drive && (idx_q == IW'(NUM_DIGITS - 1));
      wr_fire    = wr_en && wr_ready_q && (32'(wr_idx) < NUM_DIGITS);
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      idx_d      = idx_q;
      if (!en) begin
         state_d = OFF;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            OFF: begin
               state_d = BLANK;
               cnt_d   = '0;
               idx_d   = '0;
            end
            BLANK: if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
               state_d = DRIVE;
               cnt_d   = '0;
            end
            DRIVE: if (last_drive) begin
               state_d = BLANK;
               cnt_d   = '0;
               idx_d   = frame_end ? '0 : idx_q + 1'b1;
            end
            default: begin
               state_d = OFF;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
      sh_val_d   = sh_val_q;
      sh_dp_d    = sh_dp_q;
      sh_blank_d = sh_blank_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (wr_fire && wr_idx == IW'(i)) begin
            sh_val_d[i]   = wr_data;
            sh_dp_d[i]    = wr_dp;
            sh_blank_d[i] = wr_blank;
         end
      end
      // The displayed bank only moves at a frame boundary or while dark, so a frame never tears.
      commit      = (state_q == OFF) || frame_end;
      act_val_d   = commit ? sh_val_q : act_val_q;
      act_dp_d    = commit ? sh_dp_q : act_dp_q;
      act_blank_d = commit ? sh_blank_q : act_blank_q;
   end

   assign dec_hex = act_val_q[idx_d];

   segment_decoder u_dec (
      .hex_i   (dec_hex),
      .seg_n_o (dec_seg)
   );

   // Outputs are computed from the next state so the pins change on the same edge as the FSM.
   always_comb begin
      drive_d      = (state_d == DRIVE);
      lit          = drive_d && !act_blank_q[idx_d];
      an_n_d       = drive_d ? ~(NUM_DIGITS'(1) << idx_d) : '1;
      seg_n_d      = lit ? dec_seg : 7'h7F;
      dp_n_d       = !(lit && act_dp_q[idx_d]);
      wr_ready_d   = !(drive_d && idx_d == IW'(NUM_DIGITS - 1) && cnt_d == CW'(CLK_DIV - 1));
      frame_done_d = frame_end;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= OFF;
         cnt_q        <= '0;
         idx_q        <= '0;
         sh_val_q     <= '0;
         sh_dp_q      <= '0;
         sh_blank_q   <= '1;
         act_val_q    <= '0;
         act_dp_q     <= '0;
         act_blank_q  <= '1;
         an_n_q       <= '1;
         seg_n_q      <= 7'h7F;
         dp_n_q       <= 1'b1;
         frame_done_q <= 1'b0;
         wr_ready_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         sh_val_q     <= sh_val_d;
         sh_dp_q      <= sh_dp_d;
         sh_blank_q   <= sh_blank_d;
         act_val_q    <= act_val_d;
         act_dp_q     <= act_dp_d;
         act_blank_q  <= act_blank_d;
         an_n_q       <= an_n_d;
         seg_n_q      <= seg_n_d;
         dp_n_q       <= dp_n_d;
         frame_done_q <= frame_done_d;
         wr_ready_q   <= wr_ready_d;
      end
   end

   assign wr_ready   = wr_ready_q;
   assign seg_n      = seg_n_q;
   assign dp_n       = dp_n_q;
   assign an_n       = an_n_q;
   assign digit_idx  = idx_q;
   assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: directed checks of scan timing, double buffering, commit stall,
// enable drop, blanking and reset for seg_scan_controller (4 digits, plus a 3-digit instance).
module tb_seg_scan_controller;
   logic       clk = 1'b0;
   logic       rst_n, en, wr_en, wr_dp, wr_blank, wr_ready, dp_n, frame_done;
   logic [1:0] wr_idx, digit_idx;
   logic [3:0] wr_data, an_n;
   logic [6:0] seg_n;
   logic       en3, wr_en3, wr_dp3, wr_blank3, wr_ready3, dp_n3, frame_done3;
   logic [1:0] wr_idx3, digit_idx3;
   logic [3:0] wr_data3;
   logic [2:0] an_n3;
   logic [6:0] seg_n3;
   logic [6:0] exp_seg [4];
   logic       exp_dpn [4];
   int         passes = 0, total = 0;

   always #5 clk = ~clk;

   seg_scan_controller #(.NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_ready(wr_ready),
      .wr_idx(wr_idx), .wr_data(wr_data), .wr_dp(wr_dp), .wr_blank(wr_blank),
      .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .digit_idx(digit_idx), .frame_done(frame_done)
   );

   seg_scan_controller #(.NUM_DIGITS(3), .CLK_DIV(4), .BLANK_CYCLES(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .en(en3), .wr_en(wr_en3), .wr_ready(wr_ready3),
      .wr_idx(wr_idx3), .wr_data(wr_data3), .wr_dp(wr_dp3), .wr_blank(wr_blank3),
      .seg_n(seg_n3), .dp_n(dp_n3), .an_n(an_n3), .digit_idx(digit_idx3), .frame_done(frame_done3)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_dark(input string tag);
      chk({tag, " an_n"}, 32'(an_n), 32'hF);
      chk({tag, " seg_n"}, 32'(seg_n), 32'h7F);
      chk({tag, " dp_n"}, 32'(dp_n), 32'h1);
      chk({tag, " frame_done"}, 32'(frame_done), 32'h0);
   endtask

   task automatic wr(input logic [1:0] i, input logic [3:0] d, input logic dp, input logic bl);
      wr_idx = i; wr_data = d; wr_dp = dp; wr_blank = bl; wr_en = 1'b1;
      tick;
      wr_en = 1'b0;
   endtask

   // Walks n cycles of a frame from its first BLANK cycle; optionally raises a write at position wp.
   task automatic run(input bit fd0, input int n, input int wp, input logic [1:0] wi,
                      input logic [3:0] wd, input logic wdp, input logic wbl);
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dpn, e_rdy, acc;
      for (int p = 0; p < n; p++) begin
         int  d;
         bit  dr;
         d  = p / 6;
         dr = (p % 6) >= 2;
         if (p == wp) begin
            wr_idx = wi; wr_data = wd; wr_dp = wdp; wr_blank = wbl; wr_en = 1'b1;
         end
         e_an  = dr ? ~(4'b0001 << d) : 4'hF;
         e_seg = dr ? exp_seg[d] : 7'h7F;
         e_dpn = dr ? exp_dpn[d] : 1'b1;
         e_rdy = (p != 23);
         chk($sformatf("an_n p%0d", p), 32'(an_n), 32'(e_an));
         chk($sformatf("seg_n p%0d", p), 32'(seg_n), 32'(e_seg));
         chk($sformatf("dp_n p%0d", p), 32'(dp_n), 32'(e_dpn));
         chk($sformatf("digit_idx p%0d", p), 32'(digit_idx), 32'(d));
         chk($sformatf("wr_ready p%0d", p), 32'(wr_ready), 32'(e_rdy));
         chk($sformatf("frame_done p%0d", p), 32'(frame_done), 32'(p == 0 && fd0));
         acc = wr_en && e_rdy;
         tick;
         if (acc) wr_en = 1'b0;
      end
   endtask

   task automatic all_blank;
      for (int i = 0; i < 4; i++) begin
         exp_seg[i] = 7'h7F;
         exp_dpn[i] = 1'b1;
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; wr_en = 1'b1; wr_idx = 2'd0; wr_data = 4'h8; wr_dp = 1'b1; wr_blank = 1'b0;
      en3 = 1'b0; wr_en3 = 1'b0; wr_idx3 = 2'd0; wr_data3 = 4'h0; wr_dp3 = 1'b0; wr_blank3 = 1'b0;
      // Reset held with enable and a write pending: dark throughout, write ignored.
      for (int c = 0; c < 3; c++) begin
         tick;
         chk_dark($sformatf("reset c%0d", c));
         chk("reset wr_ready", 32'(wr_ready), 32'h1);
      end
      rst_n = 1'b1; wr_en = 1'b0;
      tick;
      all_blank();
      run(0, 24, -1, 0, 0, 0, 0);
      // Basic scan.
      en = 1'b0;
      tick;
      chk_dark("off");
      chk("off digit_idx", 32'(digit_idx), 32'h0);
      wr(2'd0, 4'h8, 1'b0, 1'b0);
      wr(2'd1, 4'h1, 1'b1, 1'b0);
      wr(2'd2, 4'hA, 1'b0, 1'b0);
      wr(2'd3, 4'h5, 1'b0, 1'b0);
      wr(2'd3, 4'h0, 1'b0, 1'b0);
      en = 1'b1;
      tick;
      exp_seg = '{7'h00, 7'h79, 7'h08, 7'h40};
      exp_dpn = '{1'b1, 1'b0, 1'b1, 1'b1};
      run(0, 24, -1, 0, 0, 0, 0);
      run(1, 24, -1, 0, 0, 0, 0);
      // Mid-frame write must not show until the next frame.
      run(1, 24, 0, 2'd0, 4'h5, 1'b0, 1'b0);
      exp_seg[0] = 7'h12;
      run(1, 24, -1, 0, 0, 0, 0);
      // Write held across the commit cycle is accepted one edge later.
      run(1, 24, 23, 2'd2, 4'h1, 1'b0, 1'b0);
      run(1, 24, -1, 0, 0, 0, 0);
      exp_seg[2] = 7'h79;
      run(1, 24, -1, 0, 0, 0, 0);
      // Blanked digit with dp set stays fully dark.
      run(1, 24, 0, 2'd1, 4'h8, 1'b1, 1'b1);
      exp_seg[1] = 7'h7F;
      exp_dpn[1] = 1'b1;
      run(1, 24, -1, 0, 0, 0, 0);
      // Enable drop while digit 2 drives.
      run(1, 16, -1, 0, 0, 0, 0);
      chk("pre-drop an_n", 32'(an_n), 32'hB);
      en = 1'b0;
      tick;
      chk_dark("en drop");
      chk("en drop digit_idx", 32'(digit_idx), 32'h0);
      tick;
      chk_dark("en low");
      en = 1'b1;
      tick;
      run(0, 24, -1, 0, 0, 0, 0);
      // Reset mid-frame while digit 1 slot is in progress.
      run(1, 10, -1, 0, 0, 0, 0);
      rst_n = 1'b0;
      tick;
      chk_dark("mid reset");
      chk("mid reset digit_idx", 32'(digit_idx), 32'h0);
      chk("mid reset wr_ready", 32'(wr_ready), 32'h1);
      rst_n = 1'b1;
      tick;
      all_blank();
      run(0, 24, -1, 0, 0, 0, 0);
      // Three-digit instance: out-of-range index handshakes and changes nothing.
      en = 1'b0;
      wr_idx3 = 2'd3; wr_data3 = 4'h8; wr_dp3 = 1'b1; wr_blank3 = 1'b0; wr_en3 = 1'b1;
      chk("n3 wr_ready idx3", 32'(wr_ready3), 32'h1);
      tick;
      wr_idx3 = 2'd2; wr_data3 = 4'h5; wr_dp3 = 1'b0;
      tick;
      wr_en3 = 1'b0;
      en3 = 1'b1;
      tick;
      for (int p = 0; p < 18; p++) begin
         logic [2:0] e_an3;
         logic [6:0] e_seg3;
         int d;
         bit dr;
         d      = p / 6;
         dr     = (p % 6) >= 2;
         e_an3  = dr ? ~(3'b001 << d) : 3'h7;
         e_seg3 = (dr && d == 2) ? 7'h12 : 7'h7F;
         chk($sformatf("n3 an_n p%0d", p), 32'(an_n3), 32'(e_an3));
         chk($sformatf("n3 seg_n p%0d", p), 32'(seg_n3), 32'(e_seg3));
         chk($sformatf("n3 dp_n p%0d", p), 32'(dp_n3), 32'h1);
         tick;
      end
      chk("n3 frame_done", 32'(frame_done3), 32'h1);
      chk("n3 digit_idx wrap", 32'(digit_idx3), 32'h0);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
